// File: rtl/mm_pkg.sv
// Shared definitions for the frame min/max tracker: state encoding and widths.
package mm_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/mag_cmp4.sv
// 4-bit unsigned magnitude comparator: reports a>b, a<b and a==b.
module mag_cmp4 (
  input  logic [mm_pkg::WIDTH-1:0] a,
  input  logic [mm_pkg::WIDTH-1:0] b,
  output logic                     gt,
  output logic                     lt,
  output logic                     eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/min_max_tracker.sv
// Accumulates max/min/count over a frame of samples and holds a summary
// until the consumer takes it; input is stalled while the summary is held.
module min_max_tracker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_max,
  output logic [WIDTH-1:0]         out_min,
  output logic [mm_pkg::CNT_W-1:0] out_count,
  output logic                     out_all_eq
);

  import mm_pkg::*;

  state_t             state;
  logic               xfer;
  logic               gt_max, lt_max, eq_max;
  logic               gt_min, lt_min, eq_min;
  logic [WIDTH-1:0]   nxt_max;
  logic [WIDTH-1:0]   nxt_min;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               nxt_all_eq;
  logic               close_c;

  assign xfer = in_valid & in_ready;

  mag_cmp4 u_cmp_max (
    .a  (in_data),
    .b  (out_max),
    .gt (gt_max),
    .lt (lt_max),
    .eq (eq_max)
  );

  mag_cmp4 u_cmp_min (
    .a  (in_data),
    .b  (out_min),
    .gt (gt_min),
    .lt (lt_min),
    .eq (eq_min)
  );

  // Candidate frame statistics if the current sample is accepted in ACCUM.
  // The frame stays all-equal only while every new sample matches both bounds.
  always_comb begin
    nxt_max    = out_max;
    nxt_min    = out_min;
    nxt_cnt    = out_count + CNT_W'(1);
    nxt_all_eq = out_all_eq & eq_max & eq_min;
    close_c    = in_last || (nxt_cnt == CNT_W'(FRAME_LEN));
    if (gt_max) nxt_max = in_data;
    if (lt_min) nxt_min = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_max    <= '0;
      out_min    <= '0;
      out_count  <= '0;
      out_all_eq <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            out_max    <= in_data;
            out_min    <= in_data;
            out_count  <= CNT_W'(1);
            out_all_eq <= 1'b1;
            if (in_last) begin
              state     <= REPORT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            out_max    <= nxt_max;
            out_min    <= nxt_min;
            out_count  <= nxt_cnt;
            out_all_eq <= nxt_all_eq;
            if (close_c) begin
              state     <= REPORT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_max_tracker.sv
// Directed self-checking bench for min_max_tracker (FRAME_LEN=8).
module tb_min_max_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [7:0] out_count;
  logic       out_all_eq;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] s1   [0:7] = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd7, 4'd2, 4'd15, 4'd0};
  logic [3:0] bb_d [0:7] = '{4'd6, 4'd2, 4'd9, 4'd4, 4'd11, 4'd3, 4'd5, 4'd5};
  logic       bb_l [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       bb_r [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  min_max_tracker #(.FRAME_LEN(8), .WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_count  (out_count),
    .out_all_eq (out_all_eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sum(input string tag, input logic [3:0] mx, input logic [3:0] mn,
                         input logic [7:0] cnt, input logic eq);
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    chk({tag, "_max"}, 8'(out_max), 8'(mx));
    chk({tag, "_min"}, 8'(out_min), 8'(mn));
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_all_eq"}, 8'(out_all_eq), 8'(eq));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_max", 8'(out_max), 8'd0);
    chk("rst_min", 8'(out_min), 8'd0);
    chk("rst_count", out_count, 8'd0);
    chk("rst_all_eq", 8'(out_all_eq), 8'd0);
    #10 rst_n = 1'b1;
    chk("rst_ready", 8'(in_ready), 8'd1);
    step();

    // Full frame of 8 closes on count
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("full_pre_valid", 8'(out_valid), 8'd0);
      send(s1[i], 1'b0);
    end
    chk_sum("full", 4'd15, 4'd0, 8'd8, 1'b0);
    chk("full_ready", 8'(in_ready), 8'd0);
    step();
    chk("full_done_valid", 8'(out_valid), 8'd0);
    chk("full_done_ready", 8'(in_ready), 8'd1);

    // Early close, all equal
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    send(4'd5, 1'b1);
    chk_sum("eq3", 4'd5, 4'd5, 8'd3, 1'b1);
    step();

    // Single-sample frame
    send(4'd12, 1'b1);
    chk_sum("single", 4'd12, 4'd12, 8'd1, 1'b1);
    step();

    // Back-pressure on the summary
    out_ready = 1'b0;
    send(4'd4, 1'b0);
    send(4'd10, 1'b1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k * 7);
      in_last  = 1'(k % 2);
      step();
      chk("hold_ready", 8'(in_ready), 8'd0);
      chk_sum("hold", 4'd10, 4'd4, 8'd2, 1'b0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_valid", 8'(out_valid), 8'd0);
    chk("rel_ready", 8'(in_ready), 8'd1);

    // Asynchronous reset mid-frame
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b0);
    chk("mid_count", out_count, 8'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 8'(out_valid), 8'd0);
    chk("arst_count", out_count, 8'd0);
    chk("arst_max", 8'(out_max), 8'd0);
    #1 rst_n = 1'b1;
    step();
    send(4'd8, 1'b0);
    send(4'd8, 1'b1);
    chk_sum("post_rst", 4'd8, 4'd8, 8'd2, 1'b1);
    step();

    // Back-to-back frames with continuous in_valid
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
        in_valid = 1'b1;
        in_data  = bb_d[idx];
        in_last  = bb_l[idx];
        chk("b2b_ready", 8'(in_ready), 8'(bb_r[c]));
        chk("b2b_valid", 8'(out_valid), 8'(!bb_r[c]));
        if (c == 3) chk_sum("b2b_a", 4'd9, 4'd2, 8'd3, 1'b0);
        if (c == 7) chk_sum("b2b_b", 4'd11, 4'd3, 8'd3, 1'b0);
        if (bb_r[c]) idx++;
        step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    chk("end_ready", 8'(in_ready), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/min_max_tracker.md
MIN_MAX_TRACKER -- requirements
Module: min_max_tracker

Interface
REQ-001 Parameter FRAME_LEN, default 8, samples per frame; legal range 2..255.
REQ-002 Parameter WIDTH, default 4, sample width; fixed at 4 to match the shared comparator.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  sample offered.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  4  unsigned sample.
REQ-008 in_last  input  1  accepted sample closes the frame early.
REQ-009 out_valid  output  1  frame summary available.
REQ-010 out_ready  input  1  consumer takes the summary.
REQ-011 out_max  output  4  largest sample in the frame.
REQ-012 out_min  output  4  smallest sample in the frame.
REQ-013 out_count  output  8  samples in the frame, 1..FRAME_LEN.
REQ-014 out_all_eq  output  1  all samples in the frame were equal.

Function
REQ-015 Input transfer SHALL occur iff in_valid and in_ready are high on a rising edge; output transfer iff out_valid and out_ready are high.
REQ-016 FSM SHALL have states IDLE (frame empty), ACCUM (frame open), and REPORT (summary held).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in REPORT; it SHALL be driven from state only, with no combinational path from out_ready.
REQ-018 IDLE with transfer: max=min=in_data, count=1; go to ACCUM, or go to REPORT if in_last=1.
REQ-019 ACCUM with transfer: max updates if in_data>max, min updates if in_data<min; count increments; unsigned compare via the comparator sub-module.
REQ-020 ACCUM: go to REPORT on the transfer where count reaches FRAME_LEN or in_last=1, whichever comes first.
REQ-021 out_valid SHALL be 1 exactly while in REPORT; it rises the cycle after the closing sample transfer (latency 1).
REQ-022 out_max, out_min, out_count, out_all_eq SHALL be stable throughout REPORT; out_all_eq = (max == min).
REQ-023 REPORT with out_ready=1: go to IDLE next edge; minimum frame-to-frame bubble of one input cycle.
REQ-024 REPORT with out_ready=0: hold indefinitely; in_data and in_last are ignored.
REQ-025 in_last on a FRAME_LEN-th sample SHALL close one frame only, with no empty frame emitted.
REQ-026 Equal-to-max and equal-to-min samples SHALL leave max and min unchanged.
REQ-027 out_count SHALL never exceed FRAME_LEN and SHALL never wrap.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out_valid=0, out_max=0, out_min=0, out_count=0, out_all_eq=0; in_ready SHALL be 1 once rst_n is released.
REQ-029 Reset mid-ACCUM or mid-REPORT SHALL discard the partial or pending frame; the first post-reset transfer starts a new frame.

Structure
REQ-030 Shared package mm_pkg SHALL hold the state encoding (IDLE, ACCUM, REPORT), WIDTH=4, and CNT_W=8.
REQ-031 Sub-module mag_cmp4 (4-bit unsigned compare: gt, lt, eq outputs) SHALL be instantiated twice: in_data vs max, and in_data vs min.

Verification
REQ-032 Samples 3,9,1,7,7,2,15,0 with out_ready=1 -> out_valid one cycle after the 8th transfer; max=15, min=0, count=8, all_eq=0.
REQ-033 Samples 5,5,5 with in_last on the 3rd -> max=5, min=5, count=3, all_eq=1.
REQ-034 Single sample 12 with in_last -> REPORT next cycle; max=min=12, count=1, all_eq=1.
REQ-035 out_ready=0 for 10 cycles in REPORT -> in_ready=0 and outputs stable throughout; in_data toggling has no effect; release -> IDLE, in_ready=1.
REQ-036 rst_n pulsed low after 4 samples -> out_valid=0 and count=0 asynchronously; next frame 8,8 with in_last -> max=min=8, count=2.
REQ-037 Back-to-back frames with continuous in_valid -> exactly one in_ready=0 cycle between frames; no sample lost or duplicated.
